// File: rtl/npu_result_packer.sv
// Result FIFO behind the NPU: buffers 16-bit results and, on each host read
// edge, pops up to three words into one 48-bit GPIO frame.
module npu_result_packer #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          cal_start,
  input  logic          npu_out_data_vld,
  input  logic [15:0]   npu_out_data,
  input  logic          rd_en,
  output logic [47:0]   gpio_io_o,
  output logic          out_vld,
  output logic [1:0]    out_words,
  output logic [AW:0]   fifo_count,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          overflow
);

  typedef enum logic [2:0] {IDLE, POP0, POP1, POP2, DONE} state_t;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_3    = (AW+1)'(3);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [15:0]   mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          rd_en_q;
  logic [1:0]    take_q, take_d;
  logic [47:0]   stage_q, stage_d;
  logic [47:0]   gpio_q, gpio_d;
  logic [1:0]    out_words_q, out_words_d;
  logic          out_vld_q, out_vld_d;

  logic          rd_rise, full, push, pop, in_pop, stage_clr;
  logic [1:0]    slot_sel;
  logic [2:0]    slot_we;
  logic [15:0]   head;
  logic [AW-1:0] wr_addr;

  assign rd_rise   = rd_en & ~rd_en_q;
  assign full      = (count_q == FULL_CNT);
  // A flush empties the FIFO in the same cycle, so a coincident word is always accepted.
  assign push      = npu_out_data_vld & (cal_start | ~full);
  assign head      = mem[rd_ptr_q];
  assign wr_addr   = cal_start ? '0 : wr_ptr_q;
  assign stage_clr = (state_q == IDLE) & rd_rise & ~cal_start;

  always_comb begin
    in_pop   = 1'b0;
    slot_sel = 2'd0;
    case (state_q)
      POP0:    begin in_pop = 1'b1; slot_sel = 2'd0; end
      POP1:    begin in_pop = 1'b1; slot_sel = 2'd1; end
      POP2:    begin in_pop = 1'b1; slot_sel = 2'd2; end
      default: begin in_pop = 1'b0; slot_sel = 2'd0; end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slot
      assign slot_we[gi] = in_pop & ~cal_start & (slot_sel == 2'(gi)) & (take_q > 2'(gi));
      assign stage_d[16*gi +: 16] = stage_clr   ? 16'h0000 :
                                    slot_we[gi] ? head     : stage_q[16*gi +: 16];
    end
  endgenerate

  assign pop = |slot_we;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    take_d      = take_q;
    gpio_d      = gpio_q;
    out_words_d = out_words_q;
    out_vld_d   = 1'b0;
    if (cal_start) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = push ? PTR_ONE : '0;
      count_d    = push ? CNT_ONE : '0;
      overflow_d = 1'b0;
      state_d    = IDLE;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push & ~pop)      count_d = count_q + CNT_ONE;
      else if (pop & ~push) count_d = count_q - CNT_ONE;
      if (npu_out_data_vld & full) overflow_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (rd_rise) begin
            state_d = POP0;
            take_d  = (count_q >= CNT_3) ? 2'd3 : count_q[1:0];
          end
        end
        POP0: state_d = POP1;
        POP1: state_d = POP2;
        POP2: state_d = DONE;
        DONE: begin
          gpio_d      = stage_q;
          out_words_d = take_q;
          out_vld_d   = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push & ~rst) mem[wr_addr] <= npu_out_data;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      take_q      <= 2'd0;
      stage_q     <= '0;
      gpio_q      <= '0;
      out_words_q <= 2'd0;
      out_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      rd_en_q     <= rd_en;
      take_q      <= take_d;
      stage_q     <= stage_d;
      gpio_q      <= gpio_d;
      out_words_q <= out_words_d;
      out_vld_q   <= out_vld_d;
    end
  end

  assign gpio_io_o  = gpio_q;
  assign out_vld    = out_vld_q;
  assign out_words  = out_words_q;
  assign fifo_count = count_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = full;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_npu_result_packer.sv
// Bench for npu_result_packer: directed scenarios plus random traffic, all
// compared every cycle against a queue-based model of the packer.
module tb_npu_result_packer;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          cal_start = 1'b0;
  logic          npu_out_data_vld = 1'b0;
  logic [15:0]   npu_out_data = 16'h0;
  logic          rd_en = 1'b0;
  logic [47:0]   gpio_io_o;
  logic          out_vld;
  logic [1:0]    out_words;
  logic [AW:0]   fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          overflow;

  int total = 0;
  int bad = 0;
  int vld_pulses = 0;

  // Model: queue contents, sticky overflow, last frame, and a pending pack
  // whose frame is fixed when the read edge is accepted.
  logic [15:0] mq[$];
  bit          m_ovf = 1'b0;
  bit          m_vld = 1'b0;
  bit          m_rd_prev = 1'b0;
  logic [47:0] m_gpio = '0;
  logic [47:0] m_frame = '0;
  int          m_words = 0;
  int          m_take = 0;
  int          m_age = -1;
  logic [47:0] saved_gpio;

  always #5 sys_clk = ~sys_clk;

  npu_result_packer #(.DEPTH(DEPTH)) dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .cal_start        (cal_start),
    .npu_out_data_vld (npu_out_data_vld),
    .npu_out_data     (npu_out_data),
    .rd_en            (rd_en),
    .gpio_io_o        (gpio_io_o),
    .out_vld          (out_vld),
    .out_words        (out_words),
    .fifo_count       (fifo_count),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .overflow         (overflow)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit rise;
    bit full_before;
    rise = rd_en && !m_rd_prev;
    @(posedge sys_clk);
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_gpio = '0; m_words = 0; m_vld = 0; m_age = -1; m_rd_prev = 0;
    end else begin
      m_rd_prev = rd_en;
      m_vld = 0;
      if (cal_start) begin
        mq.delete();
        m_ovf = 0;
        m_age = -1;
        if (npu_out_data_vld) mq.push_back(npu_out_data);
      end else begin
        full_before = (mq.size() == DEPTH);
        if (m_age >= 0) begin
          m_age++;
          if (m_age <= m_take) void'(mq.pop_front());
          if (m_age == 4) begin
            m_gpio = m_frame; m_words = m_take; m_vld = 1; m_age = -1;
          end
        end else if (rise) begin
          m_take = (mq.size() < 3) ? mq.size() : 3;
          m_frame = '0;
          for (int i = 0; i < m_take; i++) m_frame[16*i +: 16] = mq[i];
          m_age = 0;
        end
        if (npu_out_data_vld) begin
          if (full_before) m_ovf = 1;
          else mq.push_back(npu_out_data);
        end
      end
    end
    #1;
    chk("gpio", gpio_io_o, m_gpio);
    chk("out_words", 48'(out_words), 48'(m_words));
    chk("out_vld", 48'(out_vld), 48'(m_vld));
    chk("fifo_count", 48'(fifo_count), 48'(mq.size()));
    chk("fifo_empty", 48'(fifo_empty), 48'(mq.size() == 0));
    chk("fifo_full", 48'(fifo_full), 48'(mq.size() == DEPTH));
    chk("overflow", 48'(overflow), 48'(m_ovf));
    if (out_vld) begin
      vld_pulses++;
      $display("pack: gpio=%012h words=%0d count=%0d", gpio_io_o, out_words, fifo_count);
    end
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_gpio", gpio_io_o, 48'h0);
    chk("rst_empty", 48'(fifo_empty), 48'h1);

    // Four words, one pack of three
    npu_out_data_vld = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      npu_out_data = 16'(i * 16'h0011);
      tick();
    end
    npu_out_data_vld = 1'b0;
    rd_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("pack1_gpio", gpio_io_o, 48'h0033_0022_0011);
    chk("pack1_words", 48'(out_words), 48'd3);
    chk("pack1_vld", 48'(out_vld), 48'd1);
    chk("pack1_count", 48'(fifo_count), 48'd1);
    tick();
    chk("pack1_vld_drop", 48'(out_vld), 48'd0);
    rd_en = 1'b0;
    tick();

    // One remaining word, then an empty read
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pack2_gpio", gpio_io_o, 48'h0000_0000_0044);
    chk("pack2_words", 48'(out_words), 48'd1);
    chk("pack2_empty", 48'(fifo_empty), 48'd1);
    rd_en = 1'b0;
    tick();
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pack3_gpio", gpio_io_o, 48'h0);
    chk("pack3_words", 48'(out_words), 48'd0);
    chk("pack3_vld", 48'(out_vld), 48'd1);
    rd_en = 1'b0;
    tick();

    // Overfill, then flush
    npu_out_data_vld = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      npu_out_data = 16'(16'h0100 + i);
      tick();
    end
    npu_out_data_vld = 1'b0;
    chk("ovf_full", 48'(fifo_full), 48'd1);
    chk("ovf_count", 48'(fifo_count), 48'(DEPTH));
    chk("ovf_flag", 48'(overflow), 48'd1);
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    chk("flush_count", 48'(fifo_count), 48'd0);
    chk("flush_ovf", 48'(overflow), 48'd0);
    cal_start = 1'b1;
    npu_out_data_vld = 1'b1;
    npu_out_data = 16'hA001;
    tick();
    cal_start = 1'b0;
    chk("flush_vld_count", 48'(fifo_count), 48'd1);
    npu_out_data = 16'hA002;
    tick();

    // Pack of two while writes keep streaming in
    rd_en = 1'b1;
    npu_out_data = 16'hB000;
    tick();
    for (int i = 1; i <= 4; i++) begin
      npu_out_data = 16'(16'hB000 + i);
      tick();
    end
    chk("stream_words", 48'(out_words), 48'd2);
    chk("stream_gpio", gpio_io_o, 48'h0000_A002_A001);
    chk("stream_count", 48'(fifo_count), 48'd5);
    npu_out_data_vld = 1'b0;
    rd_en = 1'b0;
    tick();

    // rd_en toggled during POP1 yields one pack
    vld_pulses = 0;
    rd_en = 1'b1; tick();
    rd_en = 1'b0; tick();
    rd_en = 1'b1; tick();
    for (int i = 0; i < 8; i++) tick();
    chk("toggle_pulses", 48'(vld_pulses), 48'd1);
    rd_en = 1'b0;
    tick();

    // rd_en held high for 20 cycles yields one pack
    vld_pulses = 0;
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("held_pulses", 48'(vld_pulses), 48'd1);
    rd_en = 1'b0;
    tick();

    // cal_start during POP1 aborts the pack
    npu_out_data_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin npu_out_data = 16'(16'hC000 + i); tick(); end
    npu_out_data_vld = 1'b0;
    saved_gpio = m_gpio;
    vld_pulses = 0;
    rd_en = 1'b1; tick();
    rd_en = 1'b0; tick();
    cal_start = 1'b1; tick();
    cal_start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("abort_pulses", 48'(vld_pulses), 48'd0);
    chk("abort_gpio", gpio_io_o, saved_gpio);

    // rst during POP2 of a new pack
    npu_out_data_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin npu_out_data = 16'(16'hD000 + i); tick(); end
    npu_out_data_vld = 1'b0;
    rd_en = 1'b1; tick();
    rd_en = 1'b0; tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("rst2_gpio", gpio_io_o, 48'h0);
    chk("rst2_words", 48'(out_words), 48'd0);
    chk("rst2_empty", 48'(fifo_empty), 48'd1);
    chk("rst2_count", 48'(fifo_count), 48'd0);
    npu_out_data_vld = 1'b1; npu_out_data = 16'hE001; tick();
    npu_out_data_vld = 1'b0;
    rd_en = 1'b1; tick();
    for (int i = 0; i < 3; i++) tick();
    chk("rst2_idle_early", 48'(out_vld), 48'd0);
    tick();
    chk("rst2_idle_vld", 48'(out_vld), 48'd1);
    chk("rst2_idle_gpio", gpio_io_o, 48'h0000_0000_E001);
    rd_en = 1'b0;
    tick();

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      npu_out_data_vld = ($urandom_range(0, 2) != 0);
      npu_out_data     = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rd_en = ~rd_en;
      cal_start = ($urandom_range(0, 59) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; cal_start = 1'b0; npu_out_data_vld = 1'b0; rd_en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
